// File: rtl/alu_issue.sv
// alu_issue: register-file issue/writeback stage feeding a 16-bit ALU.
// Optional `ALU_ISSUE_FWD_EN: forward the EX result on RAW hazards instead of stalling one cycle.
module alu_issue #(
  parameter int unsigned RA_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [RA_W-1:0] in_rd,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic            in_imm_sel,
  input  logic [15:0]     in_imm,
  output logic [1:0]      alu_op,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  input  logic [15:0]     alu_o,
  input  logic            alu_cout,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic [15:0]     wb_data,
  output logic            flag_c,
  input  logic [RA_W-1:0] dbg_raddr,
  output logic [15:0]     dbg_rdata
);

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 1 << RA_W;
  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;

  // EX-stage payload; op/a/b double as the ALU drive registers
  typedef struct packed {
    logic [1:0]      op;
    logic [RA_W-1:0] rd;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
  } ex_t;

  logic [DW-1:0] regs [NREG];
  logic          ex_valid;
  ex_t           ex_q;
  ex_t           ex_d_c;

  logic          hit_a_c;
  logic          hit_b_c;
  logic          accept_c;
  logic          flag_upd_c;

  // Operand fetch, hazard detection and the accept handshake
  always_comb begin
    hit_a_c   = ex_valid && (ex_q.rd == in_rs1);
    hit_b_c   = ex_valid && !in_imm_sel && (ex_q.rd == in_rs2);
    ex_d_c.op = in_op;
    ex_d_c.rd = in_rd;
    ex_d_c.a  = regs[in_rs1];
    ex_d_c.b  = in_imm_sel ? in_imm : regs[in_rs2];
`ifdef ALU_ISSUE_FWD_EN
    if (hit_a_c) ex_d_c.a = alu_o;
    if (hit_b_c) ex_d_c.b = alu_o;
    in_ready = reset;
`else
    // The EX instruction retires during the stall cycle, so the retry reads the updated file
    in_ready = reset && !(hit_a_c || hit_b_c);
`endif
    accept_c = in_valid && in_ready;
  end

  // Only add/sub update the carry flag
  always_comb begin
    flag_upd_c = ex_valid && ((ex_q.op == OP_ADD) || (ex_q.op == OP_SUB));
  end

  // EX register: holds its last contents while idle so the ALU inputs stay stable
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else begin
      ex_valid <= accept_c;
      if (accept_c) begin
        ex_q <= ex_d_c;
      end
    end
  end

  // Register file write at the closing edge of EX
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[RA_W'(i)] <= '0;
      end
    end else if (ex_valid) begin
      regs[ex_q.rd] <= alu_o;
    end
  end

  // Writeback report and carry flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flag_c   <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd   <= ex_q.rd;
        wb_data <= alu_o;
      end
      if (flag_upd_c) begin
        flag_c <= alu_cout;
      end
    end
  end

  assign alu_op    = ex_q.op;
  assign alu_a     = ex_q.a;
  assign alu_b     = ex_q.b;
  assign dbg_rdata = regs[dbg_raddr];

endmodule
